// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the inter-stage pipeline register:
//   - state_t        : occupancy state of the two-entry stage (EMPTY/ONE/TWO)
//   - NOP_IR_DEFAULT : default instruction word driven in a bubble
//   - make_bubble()  : builds the bubble payload for a given lane width/count
//                      (lane 0 = NOP instruction, every other lane = 0)
package pipe_pkg;

    // The encoding equals the number of beats held, which keeps waveforms readable.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

    // Upper bounds of what make_bubble can build: one lane of up to 64 bits,
    // a whole payload of up to 1024 bits.
    localparam int MAX_LANE_W    = 64;
    localparam int MAX_PAYLOAD_W = 1024;

    // Lane 0 sits at the bottom of the payload, so the bubble is the NOP word
    // masked to one lane and zero-extended over the remaining lanes.
    function automatic logic [MAX_PAYLOAD_W-1:0] make_bubble(
        input int                    w,
        input int                    lanes,
        input logic [MAX_LANE_W-1:0] nop_ir
    );
        logic [MAX_LANE_W-1:0] mask;
        mask = (w >= MAX_LANE_W) ? '1
                                 : ((MAX_LANE_W'(1) << w) - MAX_LANE_W'(1));
        make_bubble = (lanes < 1) ? '0 : MAX_PAYLOAD_W'(nop_ir & mask);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter used for the stage performance counters.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-low; clears q
//     inc   - add one this cycle (ignored once q is all-ones)
//     clr   - synchronous clear, wins over inc
//     q     - current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register with a two-entry skid buffer. MAIN drives
//   the output; SKID catches the beat accepted while the output is stalled,
//   so in_ready depends on the state register only and never on out_ready.
//   Ports:
//     clk, reset           - clock; asynchronous active-low reset
//     in_valid/in_ready    - upstream handshake, in_data is LANES*W bits
//     out_valid/out_ready  - downstream handshake, out_data is LANES*W bits
//     flush                - synchronous kill of every held beat
//     cnt_clr              - synchronous clear of both counters
//     stall_cnt            - saturating count of cycles out_valid & !out_ready
//     bubble_cnt           - saturating count of cycles !out_valid
//     state                - current occupancy state (debug)
//   Lane k of a payload lives at bits [k*W +: W]; lane 0 is the instruction.
//   W may be at most 64 and LANES*W at most 1024.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// edge. valid never depends on ready; once raised, out_valid stays high and
// out_data stays stable until the beat is taken (or a flush/reset kills it).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int           W      = 32,
    parameter int           LANES  = 5,
    parameter logic [W-1:0] NOP_IR = W'(NOP_IR_DEFAULT),
    parameter int           CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    input  logic               flush,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output state_t             state
);

    localparam int PW = LANES * W;
    localparam logic [MAX_PAYLOAD_W-1:0] BUBBLE_FULL =
        make_bubble(W, LANES, MAX_LANE_W'(NOP_IR));
    localparam logic [PW-1:0] BUBBLE = BUBBLE_FULL[PW-1:0];

    state_t        state_q, state_d;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_fire, out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State and storage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and storage updates. MAIN is reloaded with the bubble
    // whenever it empties so out_data reads as a bubble while out_valid is low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any beat accepted this cycle is dropped; a beat taken
            // downstream this cycle has already left.
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                TWO: begin
                    // in_ready is low here, so nothing new can arrive.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean empty stage.
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake outputs are decoded from the state register alone.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state_q)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ONE: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
            end
            TWO: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    assign out_data = main_q;
    assign state    = state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .clr   (cnt_clr),
        .q     (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid),
        .clr   (cnt_clr),
        .q     (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Drives two instances from one stimulus stream: dut_a with default
//   parameters, dut_b with W=16, LANES=2, NOP_IR=16'h0013, CNT_W=4 (dut_b sees
//   the low 32 bits of the payload). A queue-based model of a two-deep FIFO
//   supplies the expected outputs every cycle; directed literals pin it.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush     = 1'b0;
    logic         cnt_clr   = 1'b0;
    logic [159:0] in_data   = '0;

    logic         a_in_ready, a_out_valid;
    logic [159:0] a_out_data;
    logic [15:0]  a_stall, a_bubble;
    state_t       a_state;

    logic         b_in_ready, b_out_valid;
    logic [31:0]  b_out_data;
    logic [3:0]   b_stall, b_bubble;
    state_t       b_state;

    pipe_stage_reg dut_a (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .in_data    (in_data),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .out_data   (a_out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (a_stall),
        .bubble_cnt (a_bubble),
        .state      (a_state)
    );

    pipe_stage_reg #(
        .W      (16),
        .LANES  (2),
        .NOP_IR (16'h0013),
        .CNT_W  (4)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .in_data    (in_data[31:0]),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .out_data   (b_out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (b_stall),
        .bubble_cnt (b_bubble),
        .state      (b_state)
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The stage behaves as a FIFO of depth two; counters saturate at their width.
    logic [159:0] mq[$];
    int m_stall_a = 0, m_bub_a = 0, m_stall_b = 0, m_bub_b = 0;
    bit m_ofire, m_ifire;

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_stall_a = 0; m_bub_a = 0; m_stall_b = 0; m_bub_b = 0;
        end else begin
            m_ofire = (mq.size() > 0) && out_ready;
            m_ifire = in_valid && (mq.size() < 2);
            if (cnt_clr) begin
                m_stall_a = 0; m_bub_a = 0; m_stall_b = 0; m_bub_b = 0;
            end else begin
                if (mq.size() > 0 && !out_ready) begin
                    m_stall_a = sat_inc(m_stall_a, 65535);
                    m_stall_b = sat_inc(m_stall_b, 15);
                end
                if (mq.size() == 0) begin
                    m_bub_a = sat_inc(m_bub_a, 65535);
                    m_bub_b = sat_inc(m_bub_b, 15);
                end
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (m_ofire) void'(mq.pop_front());
                if (m_ifire) mq.push_back(in_data);
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [31:0]  deliv_q[$];
    logic [159:0] exp_a;
    logic [31:0]  exp_b;
    state_t       exp_state;

    always @(negedge clk) begin
        exp_a     = (mq.size() > 0) ? mq[0] : 160'h0;
        exp_b     = (mq.size() > 0) ? exp_a[31:0] : 32'h0000_0013;
        exp_state = (mq.size() == 0) ? EMPTY : (mq.size() == 1) ? ONE : TWO;
        check("a_out_valid", a_out_valid, mq.size() > 0);
        check("a_in_ready",  a_in_ready,  mq.size() < 2);
        check("a_out_data",  a_out_data,  exp_a);
        check("a_stall_cnt", a_stall,     m_stall_a);
        check("a_bubble_cnt", a_bubble,   m_bub_a);
        check("a_state",     a_state,     exp_state);
        check("b_out_valid", b_out_valid, mq.size() > 0);
        check("b_in_ready",  b_in_ready,  mq.size() < 2);
        check("b_out_data",  b_out_data,  exp_b);
        check("b_stall_cnt", b_stall,     m_stall_b);
        check("b_bubble_cnt", b_bubble,   m_bub_b);
        if (a_out_valid && out_ready) deliv_q.push_back(a_out_data[31:0]);
    end

    // ---------------- driver tasks ----------------
    function automatic logic [159:0] make_payload(input logic [31:0] ir);
        return {ir ^ 32'h4444_4444, ir ^ 32'h3333_3333, ir ^ 32'h2222_2222,
                ir ^ 32'h1111_1111, ir};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ir, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = v;
        in_data   = make_payload(ir);
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_deliv(input string name, input int n,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2);
        logic [31:0] exp_list[3];
        exp_list[0] = e0; exp_list[1] = e1; exp_list[2] = e2;
        check({name, "_count"}, deliv_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check(name, (i < deliv_q.size()) ? deliv_q[i] : 32'hDEAD_DEAD, exp_list[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        @(posedge clk); #1;
        // Reset state, both instances.
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_in_ready",  a_in_ready,  1'b1);
        check("rst_a_out_data",  a_out_data,  160'h0);
        check("rst_b_out_data",  b_out_data,  32'h0000_0013);
        check("rst_b_cnts",      {b_stall, b_bubble}, 8'h00);
        @(posedge clk); #1;
        reset = 1'b1;

        // Streaming with out_ready held high.
        drive(0, 32'h0, 1, 0, 1);
        drive(1, 32'h8C01_0004, 1, 0, 0);
        check("stream_lane0_1", a_out_data[31:0], 32'h8C01_0004);
        check("stream_b_1",     b_out_data,       32'h8C01_0004);
        check("stream_lane1_1", a_out_data[63:32], 32'h9D10_1115);
        drive(1, 32'h0022_1820, 1, 0, 0);
        check("stream_lane0_2", a_out_data[31:0], 32'h0022_1820);
        drive(1, 32'hAC03_0008, 1, 0, 0);
        check("stream_lane0_3", a_out_data[31:0], 32'hAC03_0008);
        drive(0, 32'h0, 1, 0, 0);
        check("stream_drained", a_out_valid, 1'b0);
        drive(0, 32'h0, 1, 0, 0);
        check("stream_bubble_cnt", a_bubble, 16'd2);
        check("stream_stall_cnt",  a_stall,  16'd0);

        // Backpressure: A then B fill the stage, C waits.
        drive(0, 32'h0, 0, 0, 1);
        deliv_q.delete();
        drive(1, 32'h1111_1111, 0, 0, 0);
        drive(1, 32'h2222_2222, 0, 0, 0);
        check("bp_in_ready_low", a_in_ready, 1'b0);
        check("bp_state_two",    a_state,    TWO);
        drive(1, 32'h3333_0000, 0, 0, 0);
        drive(1, 32'h3333_0000, 0, 0, 0);
        drive(1, 32'h3333_0000, 1, 0, 0);
        check("bp_in_ready_back", a_in_ready, 1'b1);
        check("bp_lane0_b",       a_out_data[31:0], 32'h2222_2222);
        drive(1, 32'h3333_0000, 1, 0, 0);
        drive(0, 32'h0, 1, 0, 0);
        check_deliv("bp_order", 3, 32'h1111_1111, 32'h2222_2222, 32'h3333_0000);
        check("bp_stall_cnt", a_stall, 16'd3);

        // Flush while full with D on the input.
        deliv_q.delete();
        drive(1, 32'h4444_0001, 0, 0, 0);
        drive(1, 32'h4444_0002, 0, 0, 0);
        drive(1, 32'h3333_3333, 0, 1, 0);
        check("flush_out_valid", a_out_valid, 1'b0);
        check("flush_a_bubble",  a_out_data,  160'h0);
        check("flush_b_bubble",  b_out_data,  32'h0000_0013);
        repeat (3) drive(0, 32'h0, 1, 0, 0);
        check_deliv("flush_no_d", 0, 32'h0, 32'h0, 32'h0);
        // Flush with a simultaneous output fire: E leaves, F is dropped.
        drive(1, 32'h5555_000E, 1, 0, 0);
        drive(1, 32'h5555_000F, 1, 1, 0);
        repeat (2) drive(0, 32'h0, 1, 0, 0);
        check_deliv("flush_deliv", 1, 32'h5555_000E, 32'h0, 32'h0);

        // Saturation of the 4-bit counters.
        drive(0, 32'h0, 0, 0, 1);
        drive(1, 32'h6666_6666, 0, 0, 0);
        repeat (20) drive(0, 32'h0, 0, 0, 0);
        check("sat_b_stall", b_stall, 4'd15);
        check("sat_a_stall", a_stall, 16'd20);
        drive(0, 32'h0, 0, 0, 1);
        check("sat_clr_b", b_stall, 4'd0);
        check("sat_clr_a", a_stall, 16'd0);
        drive(0, 32'h0, 1, 0, 0);

        // Asynchronous reset mid-cycle while full.
        drive(1, 32'h7777_0001, 0, 0, 0);
        drive(1, 32'h7777_0002, 0, 0, 0);
        #3 reset = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 1'b0);
        check("arst_in_ready",  a_in_ready,  1'b1);
        check("arst_lane0",     a_out_data[31:0], 32'h0);
        check("arst_cnts",      {a_stall, a_bubble}, 32'h0);
        check("arst_b_data",    b_out_data, 32'h0000_0013);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Streaming again with 16-bit instruction words for dut_b.
        drive(1, 32'h0000_1234, 1, 0, 0);
        check("s16_first_accept", a_out_valid, 1'b1);
        check("s16_b_1", b_out_data, 32'h0000_1234);
        drive(1, 32'h0000_ABCD, 1, 0, 0);
        check("s16_b_2", b_out_data, 32'h0000_ABCD);
        drive(1, 32'h0000_0F0F, 1, 0, 0);
        check("s16_b_3", b_out_data, 32'h0000_0F0F);
        drive(0, 32'h0, 1, 0, 0);
        check("s16_b_bubble", b_out_data, 32'h0000_0013);
        drive(0, 32'h0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
